// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master.
package sysid_probe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ID,
    ERR_TS,
    ERR_TIMEOUT
  } err_e;

  // Word offsets of the two registers inside the system-ID slave.
  localparam logic OFS_ID = 1'b0;
  localparam logic OFS_TS = 1'b1;

  // Classify a completed (non-timed-out) check. An ID mismatch outranks a
  // timestamp mismatch; the latter only counts when timestamp checking is on.
  function automatic err_e classify(input logic id_ok,
                                    input logic ts_ok,
                                    input logic check_ts);
    if (!id_ok)               return ERR_ID;
    if (check_ts && !ts_ok)   return ERR_TS;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/sysid_probe_master.sv
// Avalon-MM read initiator that fetches the system-ID and build-timestamp
// words, compares them against expected values and reports pass/fail.
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1354606704,
  parameter bit          CHECK_TS           = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err,
  output logic [31:0] id_out,
  output logic [31:0] ts_out
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  // Last stall count before the limit; hitting it on a stalled cycle means
  // the counter reaches TIMEOUT_CYCLES on this edge.
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : '0;

  state_e      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        addr_q,  addr_d;
  logic        read_q,  read_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        pass_q,  pass_d;
  err_e        err_q,   err_d;
  logic [31:0] id_q,    id_d;
  logic [31:0] ts_q,    ts_d;

  logic        stall;
  logic        xfer;
  logic        timed_out;
  logic        finish;
  err_e        fin_err;

  assign stall     = read_q & avm_waitrequest;
  assign xfer      = read_q & ~avm_waitrequest;
  assign timed_out = TO_EN && stall && (cnt_q == TO_LAST);

  // State, handshake and result registers; reset drops the read strobe at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= OFS_ID;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_NONE;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  // Next-state logic: sequence the two reads, count stalls, grade the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    id_d    = id_q;
    ts_d    = ts_q;
    finish  = 1'b0;
    fin_err = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          cnt_d   = '0;
          addr_d  = OFS_ID;
          read_d  = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = ERR_NONE;
          id_d    = '0;
          ts_d    = '0;
        end
      end

      RD_ID: begin
        if (timed_out) begin
          finish  = 1'b1;
          fin_err = ERR_TIMEOUT;
        end else if (xfer) begin
          // The timestamp is fetched even after an ID mismatch so that both
          // words are always visible to boot logic.
          id_d    = avm_readdata;
          addr_d  = OFS_TS;
          cnt_d   = '0;
          state_d = RD_TS;
        end else if (stall) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RD_TS: begin
        if (timed_out) begin
          finish  = 1'b1;
          fin_err = ERR_TIMEOUT;
        end else if (xfer) begin
          ts_d    = avm_readdata;
          finish  = 1'b1;
          fin_err = classify(id_q == EXPECTED_ID,
                             avm_readdata == EXPECTED_TIMESTAMP,
                             CHECK_TS);
        end else if (stall) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      read_d  = 1'b0;
      addr_d  = OFS_ID;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = fin_err;
      pass_d  = (fin_err == ERR_NONE);
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err         = err_q;
  assign id_out      = id_q;
  assign ts_out      = ts_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Randomized self-checking bench for sysid_probe_master. Two instances run
// side by side: "a" with default parameters, "b" with CHECK_TS=0 and a
// 4-cycle timeout. Both talk to identical behavioural slaves.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1354606704;
  localparam int          STUCK  = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;

  logic        addr_a, rd_a, wr_a, busy_a, done_a, pass_a;
  logic [1:0]  err_a;
  logic [31:0] rdata_a, id_a, ts_a;
  logic        addr_b, rd_b, wr_b, busy_b, done_b, pass_b;
  logic [1:0]  err_b;
  logic [31:0] rdata_b, id_b, ts_b;

  // Slave behaviour: number of stall cycles per offset and the words returned.
  int          stall0, stall1;
  logic [31:0] id_word, ts_word;
  int          scnt_a, scnt_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  sysid_probe_master u_dut_a (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr_a), .avm_read(rd_a), .avm_waitrequest(wr_a),
    .avm_readdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err(err_a), .id_out(id_a), .ts_out(ts_a)
  );

  sysid_probe_master #(
    .EXPECTED_ID(32'h0000_0000),
    .EXPECTED_TIMESTAMP(32'd1354606704),
    .CHECK_TS(1'b0),
    .TIMEOUT_CYCLES(4)
  ) u_dut_b (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr_b), .avm_read(rd_b), .avm_waitrequest(wr_b),
    .avm_readdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err(err_b), .id_out(id_b), .ts_out(ts_b)
  );

  assign wr_a    = rd_a && (scnt_a < (addr_a ? stall1 : stall0));
  assign wr_b    = rd_b && (scnt_b < (addr_b ? stall1 : stall0));
  assign rdata_a = addr_a ? ts_word : id_word;
  assign rdata_b = addr_b ? ts_word : id_word;

  always @(posedge clock or posedge reset) begin
    if (reset)             scnt_a <= 0;
    else if (rd_a && wr_a) scnt_a <= scnt_a + 1;
    else                   scnt_a <= 0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset)             scnt_b <= 0;
    else if (rd_b && wr_b) scnt_b <= scnt_b + 1;
    else                   scnt_b <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Outcome of one check from the slave behaviour alone: timing is counted
  // in cycles after the edge that sampled start.
  task automatic model(input int T, input bit cts,
                       input logic [31:0] idw, input logic [31:0] tsw,
                       input int s0, input int s1,
                       output int dc, output int r0, output int r1,
                       output logic [1:0] e, output logic [31:0] eid,
                       output logic [31:0] ets);
    if (T != 0 && s0 >= T) begin
      r0 = T; r1 = 0; dc = T + 1; e = 2'd3; eid = '0; ets = '0;
    end else begin
      r0  = s0 + 1;
      eid = idw;
      if (T != 0 && s1 >= T) begin
        r1 = T; dc = r0 + T + 1; e = 2'd3; ets = '0;
      end else begin
        r1  = s1 + 1;
        dc  = r0 + r1 + 1;
        ets = tsw;
        if (idw != EXP_ID)           e = 2'd1;
        else if (cts && tsw != EXP_TS) e = 2'd2;
        else                         e = 2'd0;
      end
    end
  endtask

  task automatic run(input string tag, input bit pulse_mid);
    int dca, r0a, r1a, dcb, r0b, r1b;
    logic [1:0]  ea, eb;
    logic [31:0] ida, tsa, idb, tsb;
    int ca0 = 0, ca1 = 0, cba = 0, cda = 0, ata = -1;
    int cb0 = 0, cb1 = 0, cbb = 0, cdb = 0, atb = -1;
    int last;

    model(255, 1'b1, id_word, ts_word, stall0, stall1, dca, r0a, r1a, ea, ida, tsa);
    model(4,   1'b0, id_word, ts_word, stall0, stall1, dcb, r0b, r1b, eb, idb, tsb);
    last = ((dca > dcb) ? dca : dcb) + 3;

    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= last && n <= 400; n++) begin
      @(negedge clock);
      start = pulse_mid && (n == stall0 + 2);
      if (n == 1) begin
        chk($sformatf("%s.a.clear", tag), {pass_a, err_a, id_a, ts_a}, '0);
        chk($sformatf("%s.b.clear", tag), {pass_b, err_b, id_b, ts_b}, '0);
      end
      if (rd_a && !addr_a) ca0++;
      if (rd_a &&  addr_a) ca1++;
      if (busy_a)          cba++;
      if (done_a) begin cda++; if (ata < 0) ata = n; end
      if (rd_b && !addr_b) cb0++;
      if (rd_b &&  addr_b) cb1++;
      if (busy_b)          cbb++;
      if (done_b) begin cdb++; if (atb < 0) atb = n; end
    end
    start = 1'b0;

    chk($sformatf("%s.a.done_cyc", tag), ata, dca);
    chk($sformatf("%s.a.done_cnt", tag), cda, 1);
    chk($sformatf("%s.a.rd0", tag), ca0, r0a);
    chk($sformatf("%s.a.rd1", tag), ca1, r1a);
    chk($sformatf("%s.a.busy", tag), cba, dca - 1);
    chk($sformatf("%s.a.err", tag), err_a, ea);
    chk($sformatf("%s.a.pass", tag), pass_a, (ea == 2'd0));
    chk($sformatf("%s.a.id", tag), id_a, ida);
    chk($sformatf("%s.a.ts", tag), ts_a, tsa);
    chk($sformatf("%s.b.done_cyc", tag), atb, dcb);
    chk($sformatf("%s.b.done_cnt", tag), cdb, 1);
    chk($sformatf("%s.b.rd0", tag), cb0, r0b);
    chk($sformatf("%s.b.rd1", tag), cb1, r1b);
    chk($sformatf("%s.b.busy", tag), cbb, dcb - 1);
    chk($sformatf("%s.b.err", tag), err_b, eb);
    chk($sformatf("%s.b.pass", tag), pass_b, (eb == 2'd0));
    chk($sformatf("%s.b.id", tag), id_b, idb);
    chk($sformatf("%s.b.ts", tag), ts_b, tsb);
  endtask

  task automatic set_case(input logic [31:0] idw, input logic [31:0] tsw,
                          input int s0, input int s1);
    id_word = idw; ts_word = tsw; stall0 = s0; stall1 = s1;
  endtask

  function automatic int pick_stall();
    int r = $urandom_range(0, 19);
    if (r < 12) return $urandom_range(0, 3);
    if (r < 18) return $urandom_range(4, 6);
    if (r == 18) return STUCK;
    return 0;
  endfunction

  function automatic logic [31:0] pick_word(input logic [31:0] good);
    int r = $urandom_range(0, 3);
    if (r < 2)  return good;
    if (r == 2) return 32'h1;
    return $urandom;
  endfunction

  initial begin
    int ndone;
    reset = 1'b1;
    start = 1'b0;
    set_case(EXP_ID, EXP_TS, 0, 0);
    #1;
    chk("reset.a", {rd_a, addr_a, busy_a, done_a, pass_a, err_a, id_a, ts_a}, '0);
    chk("reset.b", {rd_b, addr_b, busy_b, done_b, pass_b, err_b, id_b, ts_b}, '0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    set_case(EXP_ID, EXP_TS, 0, 0);          run("nominal", 1'b0);
    set_case(32'h1,  EXP_TS, 0, 0);          run("bad_id", 1'b0);
    set_case(EXP_ID, 32'h1,  0, 0);          run("bad_ts", 1'b0);
    set_case(EXP_ID, EXP_TS, 2, 2);          run("stall2", 1'b0);
    set_case(EXP_ID, EXP_TS, STUCK, STUCK);  run("stuck", 1'b0);
    set_case(EXP_ID, EXP_TS, 3, STUCK);      run("stuck_ts", 1'b0);
    set_case(EXP_ID, EXP_TS, 1, 2);          run("mid_start", 1'b1);

    // Reset during the ID read: strobe drops without waiting for an edge,
    // and the aborted check never reports.
    set_case(EXP_ID, EXP_TS, 3, 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("rst_mid.rd_before", {rd_a, rd_b}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rst_mid.a", {rd_a, addr_a, busy_a, done_a, pass_a, err_a, id_a, ts_a}, '0);
    chk("rst_mid.b", {rd_b, addr_b, busy_b, done_b, pass_b, err_b, id_b, ts_b}, '0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (done_a || done_b || rd_a || rd_b) ndone++;
    end
    chk("rst_mid.quiet", ndone, 0);

    for (int i = 0; i < 30; i++) begin
      int s0 = pick_stall();
      int s1 = pick_stall();
      set_case(pick_word(EXP_ID), pick_word(EXP_TS), s0, s1);
      run($sformatf("rnd%0d", i), (s0 < 4) && ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
